// File: rtl/dcs_eci_tx_merge.sv
// ECI TX merge: round-robin arbiter over the rsp_wd, rsp_wod and fwd_wod DCS channels,
// feeding one registered ECI packet stage, with per-source counters and a sticky size-error flag.
module dcs_eci_tx_merge #(
    parameter int ECI_WORD_WIDTH  = 64,
    parameter int ECI_PACKET_SIZE = 17,
    parameter int SIZE_WIDTH      = 5,
    parameter int VC_WIDTH        = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0] rsp_wd_pkt_i,
    input  logic [SIZE_WIDTH-1:0]                          rsp_wd_pkt_size_i,
    input  logic [VC_WIDTH-1:0]                            rsp_wd_pkt_vc_i,
    input  logic                                           rsp_wd_pkt_valid_i,
    output logic                                           rsp_wd_pkt_ready_o,
    input  logic [ECI_WORD_WIDTH-1:0]                      rsp_wod_hdr_i,
    input  logic [SIZE_WIDTH-1:0]                          rsp_wod_pkt_size_i,
    input  logic [VC_WIDTH-1:0]                            rsp_wod_pkt_vc_i,
    input  logic                                           rsp_wod_pkt_valid_i,
    output logic                                           rsp_wod_pkt_ready_o,
    input  logic [ECI_WORD_WIDTH-1:0]                      fwd_wod_hdr_i,
    input  logic [SIZE_WIDTH-1:0]                          fwd_wod_pkt_size_i,
    input  logic [VC_WIDTH-1:0]                            fwd_wod_pkt_vc_i,
    input  logic                                           fwd_wod_pkt_valid_i,
    output logic                                           fwd_wod_pkt_ready_o,
    output logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0] eci_tx_pkt_o,
    output logic [SIZE_WIDTH-1:0]                          eci_tx_pkt_size_o,
    output logic [VC_WIDTH-1:0]                            eci_tx_pkt_vc_o,
    output logic                                           eci_tx_pkt_valid_o,
    input  logic                                           eci_tx_pkt_ready_i,
    output logic [CNT_WIDTH-1:0]                           cnt_rsp_wd_o,
    output logic [CNT_WIDTH-1:0]                           cnt_rsp_wod_o,
    output logic [CNT_WIDTH-1:0]                           cnt_fwd_wod_o,
    output logic                                           size_err_o
);

    localparam int PKT_BITS = ECI_PACKET_SIZE * ECI_WORD_WIDTH;

    logic [1:0]                                     rr_last_r;
    logic [3:0]                                     req_s;
    logic [1:0]                                     idx_a_s;
    logic [1:0]                                     idx_b_s;
    logic [1:0]                                     grant_s;
    logic                                           grant_valid_s;
    logic                                           load_en_s;
    logic                                           xfer_s;
    logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0] mux_pkt_s;
    logic [SIZE_WIDTH-1:0]                          mux_size_s;
    logic [VC_WIDTH-1:0]                            mux_vc_s;

    function automatic logic [1:0] next_idx_f(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Header-only channels must carry exactly one word; rsp_wd must carry 1..ECI_PACKET_SIZE.
    function automatic logic size_bad_f(input logic [1:0] src, input logic [SIZE_WIDTH-1:0] size);
        logic bad;
        case (src)
            2'd0:    bad = (size == {SIZE_WIDTH{1'b0}}) || (size > SIZE_WIDTH'(ECI_PACKET_SIZE));
            default: bad = (size != SIZE_WIDTH'(1));
        endcase
        return bad;
    endfunction

    // Round-robin grant starting one past the last granted source.
    always_comb begin
        req_s         = {1'b0, fwd_wod_pkt_valid_i, rsp_wod_pkt_valid_i, rsp_wd_pkt_valid_i};
        idx_a_s       = next_idx_f(rr_last_r);
        idx_b_s       = next_idx_f(idx_a_s);
        grant_s       = 2'd0;
        grant_valid_s = 1'b0;
        if (req_s[idx_a_s]) begin
            grant_s       = idx_a_s;
            grant_valid_s = 1'b1;
        end else if (req_s[idx_b_s]) begin
            grant_s       = idx_b_s;
            grant_valid_s = 1'b1;
        end else if (req_s[rr_last_r]) begin
            grant_s       = rr_last_r;
            grant_valid_s = 1'b1;
        end else begin
            grant_s       = 2'd0;
            grant_valid_s = 1'b0;
        end
        load_en_s           = !eci_tx_pkt_valid_o || eci_tx_pkt_ready_i;
        xfer_s              = load_en_s && grant_valid_s;
        rsp_wd_pkt_ready_o  = xfer_s && (grant_s == 2'd0);
        rsp_wod_pkt_ready_o = xfer_s && (grant_s == 2'd1);
        fwd_wod_pkt_ready_o = xfer_s && (grant_s == 2'd2);
    end

    // Select the granted packet; header-only sources are zero-padded above word 0.
    always_comb begin
        mux_pkt_s = {PKT_BITS{1'b0}};
        case (grant_s)
            2'd0: begin
                mux_pkt_s  = rsp_wd_pkt_i;
                mux_size_s = rsp_wd_pkt_size_i;
                mux_vc_s   = rsp_wd_pkt_vc_i;
            end
            2'd1: begin
                mux_pkt_s[0] = rsp_wod_hdr_i;
                mux_size_s   = rsp_wod_pkt_size_i;
                mux_vc_s     = rsp_wod_pkt_vc_i;
            end
            default: begin
                mux_pkt_s[0] = fwd_wod_hdr_i;
                mux_size_s   = fwd_wod_pkt_size_i;
                mux_vc_s     = fwd_wod_pkt_vc_i;
            end
        endcase
    end

    // Output stage, round-robin pointer, counters and sticky size error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eci_tx_pkt_o       <= {PKT_BITS{1'b0}};
            eci_tx_pkt_size_o  <= {SIZE_WIDTH{1'b0}};
            eci_tx_pkt_vc_o    <= {VC_WIDTH{1'b0}};
            eci_tx_pkt_valid_o <= 1'b0;
            rr_last_r          <= 2'd2;
            cnt_rsp_wd_o       <= {CNT_WIDTH{1'b0}};
            cnt_rsp_wod_o      <= {CNT_WIDTH{1'b0}};
            cnt_fwd_wod_o      <= {CNT_WIDTH{1'b0}};
            size_err_o         <= 1'b0;
        end else if (xfer_s) begin
            eci_tx_pkt_o       <= mux_pkt_s;
            eci_tx_pkt_size_o  <= mux_size_s;
            eci_tx_pkt_vc_o    <= mux_vc_s;
            eci_tx_pkt_valid_o <= 1'b1;
            rr_last_r          <= grant_s;
            if (size_bad_f(grant_s, mux_size_s)) begin
                size_err_o <= 1'b1;
            end
            case (grant_s)
                2'd0:    cnt_rsp_wd_o  <= cnt_rsp_wd_o + CNT_WIDTH'(1);
                2'd1:    cnt_rsp_wod_o <= cnt_rsp_wod_o + CNT_WIDTH'(1);
                default: cnt_fwd_wod_o <= cnt_fwd_wod_o + CNT_WIDTH'(1);
            endcase
        end else if (load_en_s) begin
            eci_tx_pkt_valid_o <= 1'b0;
        end
    end

endmodule
